guess_judge: RTL and testbench

Parametrised successor to the three-digit hint/round tracker for the number-guessing game. On each confirm press it captures an N-digit BCD guess and answer and compares them digit-serially, most-significant digit first. It then updates the higher/lower hint, round, wrong-guess counter and a per-round try budget. It sits between the keypad/answer-generator logic and the seven-segment/LED display drivers.

---
 rtl/guess_judge.sv | 196 +++++++++++++++++++
 tb/tb_guess_judge.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/guess_judge.sv
//==============================================================================
// guess_judge: digit-serial (MSD first) BCD guess judge with hint, round,
// wrong-guess and try-budget tracking. Optional lockout: HINT_LOCKOUT_EN.
// Revision: 1.0
//==============================================================================
`default_nettype none

module guess_judge #(
  parameter int NUM_DIGITS = 3,
  parameter int NUM_ROUNDS = 4,
  parameter int MAX_TRIES  = 7,
  parameter int CNT_W      = 3
) (
  input  logic                             clk,
  input  logic                             restart,
  input  logic                             confirmButton,
  input  logic [$clog2(NUM_DIGITS+1)-1:0]  max_digit,
  input  logic [4*NUM_DIGITS-1:0]          key,
  input  logic [4*NUM_DIGITS-1:0]          answer,
  output logic [1:0]                       hint,
  output logic [CNT_W-1:0]                 round,
  output logic [CNT_W-1:0]                 incorrect_guess,
  output logic [$clog2(MAX_TRIES+1)-1:0]   tries_left,
  output logic                             busy,
  output logic                             result_valid
);

  localparam int MD_W = $clog2(NUM_DIGITS+1);
  localparam int TL_W = $clog2(MAX_TRIES+1);
  localparam int DW   = 4*NUM_DIGITS;

  localparam logic [TL_W-1:0]  C_TRIES_INIT = TL_W'(MAX_TRIES);
  localparam logic [CNT_W-1:0] C_CNT_ONE    = CNT_W'(1);
  localparam logic [MD_W-1:0]  C_IDX_ONE    = MD_W'(1);
  localparam logic [1:0]       C_HINT_LOWER  = 2'b00;
  localparam logic [1:0]       C_HINT_HIGHER = 2'b01;
  localparam logic [1:0]       C_HINT_NONE   = 2'b11;
`ifdef HINT_LOCKOUT_EN
  localparam logic [TL_W-1:0]  C_TRIES_ONE  = TL_W'(1);
  localparam logic [1:0]       C_HINT_LOCK  = 2'b10;
`endif

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_CHECK  = 2'd1,
    S_LOCKED = 2'd2
  } state_t;

  state_t             r_state, w_state_nxt;
  logic               r_confirm_q;
  logic               r_inv_pend, w_inv_pend_nxt;
  logic [DW-1:0]      r_key, w_key_nxt;
  logic [DW-1:0]      r_ans, w_ans_nxt;
  logic [MD_W-1:0]    r_idx, w_idx_nxt;
  logic [1:0]         r_hint, w_hint_nxt;
  logic [CNT_W-1:0]   r_round, w_round_nxt;
  logic [CNT_W-1:0]   r_incorrect, w_incorrect_nxt;
  logic [TL_W-1:0]    r_tries, w_tries_nxt;
  logic               r_valid, w_valid_nxt;

  logic               w_press;
  logic               w_md_ok;
  logic [3:0]         w_key_dig;
  logic [3:0]         w_ans_dig;

  assign w_press = confirmButton & ~r_confirm_q & (r_state == S_IDLE);
  assign w_md_ok = (max_digit != '0) && (int'(max_digit) <= NUM_DIGITS);

  // Digit currently under comparison, selected from the captured operands
  always_comb begin
    w_key_dig = '0;
    w_ans_dig = '0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (r_idx == MD_W'(i)) begin
        w_key_dig = r_key[4*i +: 4];
        w_ans_dig = r_ans[4*i +: 4];
      end
    end
  end

  always_comb begin
    w_state_nxt     = r_state;
    w_inv_pend_nxt  = 1'b0;
    w_key_nxt       = r_key;
    w_ans_nxt       = r_ans;
    w_idx_nxt       = r_idx;
    w_hint_nxt      = r_hint;
    w_round_nxt     = r_round;
    w_incorrect_nxt = r_incorrect;
    w_tries_nxt     = r_tries;
    w_valid_nxt     = 1'b0;

    case (r_state)
      S_IDLE: begin
        // An invalid digit count restores the power-up scoreboard one edge later
        if (r_inv_pend) begin
          w_hint_nxt      = C_HINT_NONE;
          w_round_nxt     = C_CNT_ONE;
          w_incorrect_nxt = '0;
          w_tries_nxt     = C_TRIES_INIT;
          w_valid_nxt     = 1'b1;
        end
        if (w_press) begin
          if (w_md_ok) begin
            w_key_nxt   = key;
            w_ans_nxt   = answer;
            w_idx_nxt   = max_digit - C_IDX_ONE;
            w_state_nxt = S_CHECK;
          end else begin
            w_inv_pend_nxt = 1'b1;
          end
        end
      end

      S_CHECK: begin
        if ((w_key_dig != w_ans_dig) || (r_idx == '0)) begin
          w_valid_nxt = 1'b1;
          w_state_nxt = S_IDLE;
          if (w_key_dig == w_ans_dig) begin
            w_hint_nxt  = C_HINT_NONE;
            w_round_nxt = (int'(r_round) < NUM_ROUNDS) ? (r_round + C_CNT_ONE) : '0;
            w_tries_nxt = C_TRIES_INIT;
          end else begin
            w_hint_nxt = (w_key_dig > w_ans_dig) ? C_HINT_LOWER : C_HINT_HIGHER;
            if (r_incorrect != '1) begin
              w_incorrect_nxt = r_incorrect + C_CNT_ONE;
            end
`ifdef HINT_LOCKOUT_EN
            if (r_tries != '0) begin
              w_tries_nxt = r_tries - C_TRIES_ONE;
            end
            if (r_tries == C_TRIES_ONE) begin
              w_hint_nxt  = C_HINT_LOCK;
              w_state_nxt = S_LOCKED;
            end
`endif
          end
        end else begin
          w_idx_nxt = r_idx - C_IDX_ONE;
        end
      end

      S_LOCKED: begin
        w_state_nxt = S_LOCKED;
      end

      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge restart) begin
    if (!restart) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_ff @(posedge clk or negedge restart) begin
    if (!restart) begin
      r_confirm_q <= 1'b0;
      r_inv_pend  <= 1'b0;
      r_key       <= '0;
      r_ans       <= '0;
      r_idx       <= '0;
      r_hint      <= C_HINT_NONE;
      r_round     <= C_CNT_ONE;
      r_incorrect <= '0;
      r_tries     <= C_TRIES_INIT;
      r_valid     <= 1'b0;
    end else begin
      r_confirm_q <= confirmButton;
      r_inv_pend  <= w_inv_pend_nxt;
      r_key       <= w_key_nxt;
      r_ans       <= w_ans_nxt;
      r_idx       <= w_idx_nxt;
      r_hint      <= w_hint_nxt;
      r_round     <= w_round_nxt;
      r_incorrect <= w_incorrect_nxt;
      r_tries     <= w_tries_nxt;
      r_valid     <= w_valid_nxt;
    end
  end

  assign hint            = r_hint;
  assign round           = r_round;
  assign incorrect_guess = r_incorrect;
  assign tries_left      = r_tries;
  assign busy            = (r_state == S_CHECK);
  assign result_valid    = r_valid;

endmodule

`default_nettype wire

// File: tb/tb_guess_judge.sv
//==============================================================================
// tb_guess_judge: table-driven check of guess_judge (default parameters) plus
// hand-written sequences for busy presses, restart and lockout/saturation.
// Revision: 1.0
//==============================================================================
`default_nettype none

module tb_guess_judge;

  localparam int MAX_T = 7;
  localparam int NV    = 12;

  logic        clk;
  logic        restart;
  logic        confirmButton;
  logic [1:0]  max_digit;
  logic [11:0] key;
  logic [11:0] answer;
  logic [1:0]  hint;
  logic [2:0]  round;
  logic [2:0]  incorrect_guess;
  logic [2:0]  tries_left;
  logic        busy;
  logic        result_valid;

  int n_checks = 0;
  int n_fail   = 0;

  guess_judge #(
    .NUM_DIGITS (3),
    .NUM_ROUNDS (4),
    .MAX_TRIES  (MAX_T),
    .CNT_W      (3)
  ) dut (
    .clk             (clk),
    .restart         (restart),
    .confirmButton   (confirmButton),
    .max_digit       (max_digit),
    .key             (key),
    .answer          (answer),
    .hint,
    .round           (round),
    .incorrect_guess (incorrect_guess),
    .tries_left      (tries_left),
    .busy            (busy),
    .result_valid    (result_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  md;
    logic [11:0] k;
    logic [11:0] a;
    int          lat;
    int          bsy;
    logic [1:0]  hint;
    int          round;
    int          inc;
    int          tries_lk;
  } vec_t;

  vec_t vecs [NV];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, required %0d", nm, act, exp);
    end
  endtask

  // Called just after the press edge; bounded wait for the result pulse.
  task automatic wait_result(output int lat, output int bsy);
    lat = 0;
    bsy = 0;
    while (result_valid !== 1'b1 && lat < 20) begin
      if (busy === 1'b1) bsy++;
      @(posedge clk); #1;
      lat++;
    end
    chk("busy_low_at_result", {31'd0, busy}, 0);
    @(posedge clk); #1;
    chk("result_valid_one_cycle", {31'd0, result_valid}, 0);
  endtask

  task automatic press(input logic [1:0] md, input logic [11:0] k, input logic [11:0] a,
                       output int lat, output int bsy);
    @(negedge clk);
    confirmButton = 1'b0;
    max_digit     = md;
    key           = k;
    answer        = a;
    @(negedge clk);
    confirmButton = 1'b1;
    @(posedge clk); #1;
    // Operands must already be captured; disturb the live inputs
    key       = ~k;
    answer    = k;
    max_digit = 2'd1;
    wait_result(lat, bsy);
  endtask

  task automatic chk_state(input string nm, input int h, input int r, input int inc, input int t);
    chk({nm, "_hint"},  {30'd0, hint}, h);
    chk({nm, "_round"}, {29'd0, round}, r);
    chk({nm, "_inc"},   {29'd0, incorrect_guess}, inc);
    chk({nm, "_tries"}, {29'd0, tries_left}, t);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, required finish");
    $fatal(1);
  end

  initial begin
    int lat;
    int bsy;
    int et;
    int vcnt;
    int bcnt;

    vecs[0]  = '{2'd3, 12'h572, 12'h572, 3, 3, 2'b11, 2, 0, 7};
    vecs[1]  = '{2'd3, 12'h672, 12'h572, 1, 1, 2'b00, 2, 1, 6};
    vecs[2]  = '{2'd2, 12'h347, 12'h549, 2, 2, 2'b01, 2, 2, 5};
    vecs[3]  = '{2'd3, 12'h571, 12'h572, 3, 3, 2'b01, 2, 3, 4};
    vecs[4]  = '{2'd1, 12'h123, 12'h993, 1, 1, 2'b11, 3, 3, 7};
    vecs[5]  = '{2'd3, 12'h999, 12'h099, 1, 1, 2'b00, 3, 4, 6};
    vecs[6]  = '{2'd2, 12'h085, 12'h081, 2, 2, 2'b00, 3, 5, 5};
    vecs[7]  = '{2'd3, 12'h000, 12'h000, 3, 3, 2'b11, 4, 5, 7};
    vecs[8]  = '{2'd3, 12'h123, 12'h123, 3, 3, 2'b11, 0, 5, 7};
    vecs[9]  = '{2'd2, 12'h045, 12'h045, 2, 2, 2'b11, 1, 5, 7};
    vecs[10] = '{2'd0, 12'h111, 12'h222, 1, 0, 2'b11, 1, 0, 7};
    vecs[11] = '{2'd3, 12'h500, 12'h499, 1, 1, 2'b00, 1, 1, 6};

    restart       = 1'b0;
    confirmButton = 1'b0;
    max_digit     = 2'd0;
    key           = '0;
    answer        = '0;
    @(negedge clk);
    @(negedge clk);
    chk_state("reset", 3, 1, 0, MAX_T);
    chk("reset_busy",  {31'd0, busy}, 0);
    chk("reset_valid", {31'd0, result_valid}, 0);
    restart = 1'b1;

    for (int i = 0; i < NV; i++) begin
      press(vecs[i].md, vecs[i].k, vecs[i].a, lat, bsy);
`ifdef HINT_LOCKOUT_EN
      et = vecs[i].tries_lk;
`else
      et = MAX_T;
`endif
      chk($sformatf("v%0d_latency", i), lat, vecs[i].lat);
      chk($sformatf("v%0d_busy_cycles", i), bsy, vecs[i].bsy);
      chk_state($sformatf("v%0d", i), int'(vecs[i].hint), vecs[i].round, vecs[i].inc, et);
    end

    // Fresh rising edge while busy is discarded, not queued
    @(negedge clk);
    confirmButton = 1'b0;
    max_digit     = 2'd3;
    key           = 12'h246;
    answer        = 12'h246;
    @(negedge clk);
    confirmButton = 1'b1;
    @(posedge clk); #1;
    chk("busy_after_press", {31'd0, busy}, 1);
    @(negedge clk);
    confirmButton = 1'b0;
    @(negedge clk);
    confirmButton = 1'b1;
    vcnt = 0;
    bcnt = 0;
    for (int c = 0; c < 10; c++) begin
      if (busy === 1'b1) bcnt++;
      if (result_valid === 1'b1) vcnt++;
      @(posedge clk); #1;
    end
    chk("busy_press_valid_pulses", vcnt, 1);
    chk("busy_press_busy_cycles", bcnt, 2);
    chk_state("busy_press", 3, 2, 1, MAX_T);

    // Restart during the second CHECK cycle aborts without a pulse
    @(negedge clk);
    confirmButton = 1'b0;
    key           = 12'h111;
    answer        = 12'h111;
    max_digit     = 2'd3;
    @(negedge clk);
    confirmButton = 1'b1;
    @(posedge clk);
    @(posedge clk); #1;
    restart = 1'b0;
    #1;
    chk_state("abort", 3, 1, 0, MAX_T);
    chk("abort_busy",  {31'd0, busy}, 0);
    chk("abort_valid", {31'd0, result_valid}, 0);
    @(negedge clk);
    confirmButton = 1'b0;
    @(negedge clk);
    restart = 1'b1;
    vcnt = 0;
    bcnt = 0;
    for (int c = 0; c < 6; c++) begin
      @(posedge clk); #1;
      if (busy === 1'b1) bcnt++;
      if (result_valid === 1'b1) vcnt++;
    end
    chk("abort_no_valid", vcnt, 0);
    chk("abort_no_busy", bcnt, 0);
    chk_state("abort_after", 3, 1, 0, MAX_T);

    // Button held high through restart release counts as a press
    @(negedge clk);
    restart       = 1'b0;
    confirmButton = 1'b1;
    max_digit     = 2'd3;
    key           = 12'h321;
    answer        = 12'h321;
    @(negedge clk);
    restart = 1'b1;
    @(posedge clk); #1;
    wait_result(lat, bsy);
    chk("held_release_latency", lat, 3);
    chk("held_release_busy", bsy, 3);
    chk_state("held_release", 3, 2, 0, MAX_T);

`ifdef HINT_LOCKOUT_EN
    for (int n = 1; n <= MAX_T; n++) begin
      press(2'd3, 12'h900, 12'h100, lat, bsy);
      chk($sformatf("lock%0d_latency", n), lat, 1);
      chk_state($sformatf("lock%0d", n), (n == MAX_T) ? 2 : 0, 2, n, MAX_T - n);
    end
    @(negedge clk);
    confirmButton = 1'b0;
    @(negedge clk);
    confirmButton = 1'b1;
    vcnt = 0;
    bcnt = 0;
    for (int c = 0; c < 8; c++) begin
      @(posedge clk); #1;
      if (busy === 1'b1) bcnt++;
      if (result_valid === 1'b1) vcnt++;
    end
    chk("locked_no_valid", vcnt, 0);
    chk("locked_no_busy", bcnt, 0);
    chk_state("locked", 2, 2, MAX_T, 0);
    @(negedge clk);
    confirmButton = 1'b0;
    restart       = 1'b0;
    #1;
    chk_state("unlock", 3, 1, 0, MAX_T);
    @(negedge clk);
    restart = 1'b1;
    press(2'd3, 12'h777, 12'h777, lat, bsy);
    chk("unlock_latency", lat, 3);
    chk_state("unlock_after", 3, 2, 0, MAX_T);
`else
    for (int n = 1; n <= 8; n++) begin
      press(2'd3, 12'h900, 12'h100, lat, bsy);
      chk($sformatf("sat%0d_latency", n), lat, 1);
      chk_state($sformatf("sat%0d", n), 0, 2, (n > 7) ? 7 : n, MAX_T);
    end
`endif

    @(negedge clk);
    confirmButton = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
